bus_target_v1: RTL and testbench
================================

Name: bus_target_v1

Overview:
- Target-side responder for the shared master/target bus handshake (barq/bagd, addressvalid, TargetReady, DataStrobe, Error).
- Decodes the muxed address when addressvalid rises, inserts programmable wait states, then raises TargetReady.
- On DataStrobe it completes the read or write against a local register bank. On Error it abandons the transfer.
- One instance per slave device on the bus; the address windows of all instances must not overlap.

Parameters:
- AddrWidth, 16, width of bus address.
- DataWidth, 16, width of bus data.
- BaseAddr, 16'h0100, first address of this target's window.
- NumRegs, 8, registers in window (power of 2, 2..64); window is BaseAddr..BaseAddr+NumRegs-1.
- WaitStates, 2, clocks between decode and TargetReady (0..15). Must be <= ClockMaxTimout-3 of the bus controller for error-free completion.

Ports:
- clock, in, 1, system clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- addressvalid, in, 1, bus address stable; level held for whole transfer.
- address, in, AddrWidth, bus address, valid while addressvalid=1.
- write, in, 1, 1=write, 0=read; valid while addressvalid=1.
- wdata, in, DataWidth, write data, valid in DataStrobe cycle.
- DataStrobe, in, 1, one-clock completion pulse.
- Error, in, 1, one-clock timeout pulse.
- TargetReady, out, 1, target has decoded and is ready.
- rdata, out, DataWidth, read data.
- rdata_oe, out, 1, drive enable for rdata onto the external data mux.
- regs_out, out, NumRegs*DataWidth, flat copy of register bank; reg i at bits [i*DataWidth +: DataWidth].
- wr_pulse, out, 1, one clock high after a committed write.
- wr_index, out, $clog2(NumRegs), index of the last committed write.
- abort_count, out, 8, saturating count of transfers ended by Error.

Behaviour:
- Reset (async, reset_n=0): state IDLE; TargetReady=0, rdata=0, rdata_oe=0, all registers=0, wr_pulse=0, wr_index=0, abort_count=0.
- IDLE: at an edge where addressvalid=1:
  - Latch idx=address-BaseAddr, the write bit, and hit=(address within window).
  - Hit: go to WAIT, load cnt=WaitStates, capture rdata<=reg[idx].
  - Miss: go to MISS; no outputs change.
- WAIT: if cnt==0 go to READY, else cnt<=cnt-1. TargetReady therefore rises WaitStates+1 clocks after the sampling edge.
- READY: TargetReady=1, held until the transfer ends; rdata_oe=1 if a read.
  - DataStrobe=1 and write latched: reg[idx]<=wdata, wr_pulse=1 next clock, wr_index<=idx; go to DONE.
  - DataStrobe=1 and read: go to DONE; rdata stays valid through the DataStrobe cycle.
- Error=1 in WAIT or READY: no register write; abort_count<=abort_count+1, saturating at 255; go to DONE.
- DONE: TargetReady=0, rdata_oe=0; return to IDLE once addressvalid=0.
- MISS: TargetReady never asserted; return to IDLE once addressvalid=0.
- addressvalid=0 in WAIT or READY (master withdrew): go to IDLE next edge, outputs cleared, no write, abort_count unchanged.
- DataStrobe and Error in the same cycle: DataStrobe wins (write commits); abort_count unchanged.
- DataStrobe or Error while in IDLE, MISS or DONE: ignored.
- TargetReady, rdata_oe and wr_pulse are registered (glitch-free).
- Registers are writable only via the bus; regs_out updates the clock after the write edge.
- Address arithmetic is unsigned, AddrWidth wide; subtraction is valid only when hit=1.

Decomposition:
- Package bus_target_pkg holds:
  - state enum {IDLE, WAIT, READY, DONE, MISS}
  - function addr_hit(address, BaseAddr, NumRegs)
  - localparam for abort_count width (8)
- Sub-module bus_target_regbank: NumRegs x DataWidth storage with async reset, write port (en, idx, data), registered read port and the flat regs_out. The FSM stays in the top module.

Test Plan:
- WaitStates=2: addressvalid=1 at edge 0 with address=16'h0103, write=1; DataStrobe one clock after TargetReady rises with wdata=16'hBEEF -> TargetReady rises after edge 3; reg[3]=16'hBEEF; wr_pulse=1 for one clock; wr_index=3.
- Read of 16'h0103 after the write above -> rdata=16'hBEEF and rdata_oe=1 while TargetReady=1; rdata_oe=0 after DataStrobe.
- address=16'h0200 (miss), addressvalid held 12 clocks, Error pulse -> TargetReady stays 0; abort_count stays 0; state returns to IDLE when addressvalid=0.
- Hit write at 16'h0101, Error pulse instead of DataStrobe -> reg[1] unchanged; abort_count=1. Repeat 300 times -> abort_count=255.
- DataStrobe and Error together in READY for a write of 16'h1234 to 16'h0100 -> reg[0]=16'h1234; abort_count unchanged.
- reset_n=0 mid-READY -> TargetReady, rdata_oe, all registers and abort_count are 0 immediately (async); next transfer completes normally after release.

Source files
------------

// File: rtl/bus_target_pkg.sv
// Shared types and helpers for the bus target: FSM state encoding, the
// abort counter width and the address window decode.
package bus_target_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    READY = 3'd2,
    DONE  = 3'd3,
    MISS  = 3'd4
  } state_t;

  localparam int ABORT_W = 8;

  // The difference is only meaningful once address >= base, so the
  // upper bound is checked on the offset and cannot overflow.
  function automatic logic addr_hit(input logic [31:0] address,
                                    input logic [31:0] base,
                                    input logic [31:0] nregs);
    return (address >= base) && ((address - base) < nregs);
  endfunction

endpackage

// File: rtl/bus_target_v1_if.sv
// Master/target bus handshake bundle shared by one master and its targets.
interface bus_target_v1_if #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 16
);
  // Handshake: the master holds addressvalid (with address/write) for the
  // whole transfer; the target raises TargetReady once decoded; the master
  // then issues a single-cycle DataStrobe to complete, or Error to abandon.
  // Dropping addressvalid at any point withdraws the transfer.
  logic                 addressvalid;
  logic [AddrWidth-1:0] address;
  logic                 write;
  logic [DataWidth-1:0] wdata;
  logic                 DataStrobe;
  logic                 Error;
  logic                 TargetReady;
  logic [DataWidth-1:0] rdata;
  logic                 rdata_oe;

  modport master (
    output addressvalid, address, write, wdata, DataStrobe, Error,
    input  TargetReady, rdata, rdata_oe
  );

  modport slave (
    input  addressvalid, address, write, wdata, DataStrobe, Error,
    output TargetReady, rdata, rdata_oe
  );
endinterface

// File: rtl/bus_target_regbank.sv
// Register bank for the bus target: one write port, one registered read
// port and a flat view of all registers.
module bus_target_regbank #(
  parameter int NumRegs   = 8,
  parameter int DataWidth = 16,
  localparam int IW       = $clog2(NumRegs)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [IW-1:0]                widx,
  input  logic [DataWidth-1:0]         wdata,
  input  logic                         re,
  input  logic                         rclr,
  input  logic [IW-1:0]                ridx,
  output logic [DataWidth-1:0]         rdata,
  output logic [NumRegs*DataWidth-1:0] regs_out
);

  logic [DataWidth-1:0] mem [NumRegs];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[widx] <= wdata;
      if (rclr)    rdata <= '0;
      else if (re) rdata <= mem[ridx];
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_flat
    assign regs_out[g*DataWidth +: DataWidth] = mem[g];
  end

endmodule

// File: rtl/bus_target_v1.sv
// Bus target: decodes its address window, inserts wait states, then
// completes reads/writes against a local register bank or counts aborts.
module bus_target_v1
  import bus_target_pkg::*;
#(
  parameter int                   AddrWidth  = 16,
  parameter int                   DataWidth  = 16,
  parameter logic [AddrWidth-1:0] BaseAddr   = 16'h0100,
  parameter int                   NumRegs    = 8,
  parameter int                   WaitStates = 2,
  localparam int                  IW         = $clog2(NumRegs)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  bus_target_v1_if.slave               bus,
  output logic [NumRegs*DataWidth-1:0] regs_out,
  output logic                         wr_pulse,
  output logic [IW-1:0]                wr_index,
  output logic [ABORT_W-1:0]           abort_count,
  output state_t                       state_dbg
);

  state_t               state;
  logic [3:0]           cnt;
  logic [IW-1:0]        idx_l;
  logic                 wr_l;
  logic [AddrWidth-1:0] offset;
  logic [IW-1:0]        addr_idx;
  logic                 hit;
  logic                 bank_we;
  logic                 bank_re;
  logic                 bank_rclr;

  assign offset    = bus.address - BaseAddr;
  assign addr_idx  = offset[IW-1:0];
  assign hit       = addr_hit(32'(bus.address), 32'(BaseAddr), 32'(NumRegs));
  assign state_dbg = state;

  assign bank_re   = (state == IDLE) && bus.addressvalid && hit;
  assign bank_we   = (state == READY) && bus.addressvalid && bus.DataStrobe && wr_l;
  assign bank_rclr = ((state == WAIT) || (state == READY)) && !bus.addressvalid;

  bus_target_regbank #(
    .NumRegs   (NumRegs),
    .DataWidth (DataWidth)
  ) u_regbank (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (bank_we),
    .widx     (idx_l),
    .wdata    (bus.wdata),
    .re       (bank_re),
    .rclr     (bank_rclr),
    .ridx     (addr_idx),
    .rdata    (bus.rdata),
    .regs_out (regs_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      idx_l           <= '0;
      wr_l            <= 1'b0;
      bus.TargetReady <= 1'b0;
      bus.rdata_oe    <= 1'b0;
      wr_pulse        <= 1'b0;
      wr_index        <= '0;
      abort_count     <= '0;
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.addressvalid) begin
            idx_l <= addr_idx;
            wr_l  <= bus.write;
            if (hit) begin
              state <= WAIT;
              cnt   <= 4'(WaitStates);
            end else begin
              state <= MISS;
            end
          end
        end
        WAIT: begin
          // Withdrawal outranks everything; DataStrobe is meaningless here.
          if (!bus.addressvalid) begin
            state <= IDLE;
          end else if (bus.Error) begin
            if (abort_count != '1) abort_count <= abort_count + 1'b1;
            state <= DONE;
          end else if (cnt == '0) begin
            state           <= READY;
            bus.TargetReady <= 1'b1;
            bus.rdata_oe    <= !wr_l;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READY: begin
          if (!bus.addressvalid) begin
            state           <= IDLE;
            bus.TargetReady <= 1'b0;
            bus.rdata_oe    <= 1'b0;
          end else if (bus.DataStrobe) begin
            if (wr_l) begin
              wr_pulse <= 1'b1;
              wr_index <= idx_l;
            end
            state           <= DONE;
            bus.TargetReady <= 1'b0;
            bus.rdata_oe    <= 1'b0;
          end else if (bus.Error) begin
            if (abort_count != '1) abort_count <= abort_count + 1'b1;
            state           <= DONE;
            bus.TargetReady <= 1'b0;
            bus.rdata_oe    <= 1'b0;
          end
        end
        DONE, MISS: begin
          if (!bus.addressvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_target_v1.sv
// Directed bench for bus_target_v1 with a transaction-level model of the
// register bank, abort counter and handshake timing.
module tb_bus_target_v1;
  import bus_target_pkg::*;

  localparam int WS       = 2;
  localparam int K_STROBE = 0;
  localparam int K_ERROR  = 1;
  localparam int K_BOTH   = 2;
  localparam int K_WD     = 3;
  localparam int K_HOLD   = 4;

  logic         clock;
  logic         reset_n;
  logic [127:0] regs_out;
  logic         wr_pulse;
  logic [2:0]   wr_index;
  logic [7:0]   abort_count;
  state_t       state_dbg;

  bus_target_v1_if #(.AddrWidth(16), .DataWidth(16)) bus ();

  bus_target_v1 #(
    .AddrWidth  (16),
    .DataWidth  (16),
    .BaseAddr   (16'h0100),
    .NumRegs    (8),
    .WaitStates (WS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .regs_out    (regs_out),
    .wr_pulse    (wr_pulse),
    .wr_index    (wr_index),
    .abort_count (abort_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model and scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_regs [8];
  int          m_abort;
  logic        exp_tr, exp_oe, exp_wp, chk_rdata;
  logic [2:0]  exp_widx;
  int          exp_ridx;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_abort   = 0;
    exp_tr    = 0;
    exp_oe    = 0;
    exp_wp    = 0;
    chk_rdata = 0;
    exp_widx  = '0;
    exp_ridx  = 0;
  endtask

  always @(negedge clock) begin
    logic [127:0] flat;
    if (reset_n) begin
      for (int i = 0; i < 8; i++) flat[i*16 +: 16] = m_regs[i];
      check("c_tready", bus.TargetReady, exp_tr);
      check("c_oe", bus.rdata_oe, exp_oe);
      check("c_wr_pulse", wr_pulse, exp_wp);
      check("c_wr_index", wr_index, exp_widx);
      check("c_abort", abort_count, m_abort[7:0]);
      check("c_regs", regs_out, flat);
      if (chk_rdata) check("c_rdata", bus.rdata, m_regs[exp_ridx]);
    end
  end

  // drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic [15:0] addr, input logic wr,
                      input logic [15:0] data, input int kind);
    bit hit;
    int idx;
    bit strobe, err;
    hit = (addr >= 16'h0100) && (addr <= 16'h0107);
    idx = int'(addr) - 'h100;
    bus.addressvalid = 1'b1;
    bus.address      = addr;
    bus.write        = wr;
    bus.wdata        = data;
    if (!hit) begin
      tick();
      check("miss_state", state_dbg, MISS);
      repeat (5) tick();
      bus.Error = 1'b1;
      tick();
      bus.Error = 1'b0;
      repeat (6) tick();
      bus.addressvalid = 1'b0;
      tick();
      check("miss_idle", state_dbg, IDLE);
      return;
    end
    if (!wr) exp_q.push_back(m_regs[idx]);
    tick();
    repeat (WS) tick();
    check("tr_pre", bus.TargetReady, 1'b0);
    tick();
    check("tr_rise", bus.TargetReady, 1'b1);
    exp_tr    = 1'b1;
    exp_oe    = !wr;
    exp_ridx  = idx;
    chk_rdata = !wr;
    tick();
    if (kind == K_HOLD) return;
    if (kind == K_WD) begin
      bus.addressvalid = 1'b0;
      tick();
      exp_tr    = 1'b0;
      exp_oe    = 1'b0;
      chk_rdata = 1'b0;
      check("wd_idle", state_dbg, IDLE);
      return;
    end
    strobe = (kind == K_STROBE) || (kind == K_BOTH);
    err    = (kind == K_ERROR) || (kind == K_BOTH);
    bus.DataStrobe = strobe;
    bus.Error      = err;
    if (!wr) check("rd_data", bus.rdata, exp_q.pop_front());
    tick();
    bus.DataStrobe = 1'b0;
    bus.Error      = 1'b0;
    exp_tr    = 1'b0;
    exp_oe    = 1'b0;
    chk_rdata = 1'b0;
    if (strobe && wr) begin
      m_regs[idx] = data;
      exp_wp      = 1'b1;
      exp_widx    = 3'(idx);
    end else if (err && !strobe) begin
      if (m_abort < 255) m_abort++;
    end
    check("done_state", state_dbg, DONE);
    tick();
    exp_wp = 1'b0;
    bus.addressvalid = 1'b0;
    tick();
    check("idle_state", state_dbg, IDLE);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.addressvalid = 1'b0;
    bus.address      = '0;
    bus.write        = 1'b0;
    bus.wdata        = '0;
    bus.DataStrobe   = 1'b0;
    bus.Error        = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_tready", bus.TargetReady, 1'b0);
    check("rst_oe", bus.rdata_oe, 1'b0);
    check("rst_rdata", bus.rdata, 16'h0);
    check("rst_regs", regs_out, 128'h0);
    check("rst_abort", abort_count, 8'h0);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    tick();

    xfer(16'h0103, 1'b1, 16'hBEEF, K_STROBE);
    check("pin_reg3", regs_out[63:48], 16'hBEEF);
    check("pin_widx3", wr_index, 3'd3);

    xfer(16'h0103, 1'b0, 16'h0000, K_STROBE);
    xfer(16'h0200, 1'b0, 16'h0000, K_STROBE);
    check("pin_miss_abort", abort_count, 8'd0);

    xfer(16'h0101, 1'b1, 16'h5555, K_ERROR);
    check("pin_reg1", regs_out[31:16], 16'h0000);
    check("pin_abort1", abort_count, 8'd1);

    xfer(16'h0100, 1'b1, 16'h1234, K_BOTH);
    check("pin_reg0", regs_out[15:0], 16'h1234);
    check("pin_abort_both", abort_count, 8'd1);

    for (int i = 0; i < 299; i++) xfer(16'h0101, 1'b1, 16'h5555, K_ERROR);
    check("pin_abort_sat", abort_count, 8'd255);

    xfer(16'h0107, 1'b1, 16'hA5A5, K_STROBE);
    check("pin_reg7", regs_out[127:112], 16'hA5A5);
    xfer(16'h0107, 1'b0, 16'h0000, K_STROBE);
    xfer(16'h00FF, 1'b1, 16'hFFFF, K_STROBE);
    xfer(16'h0108, 1'b1, 16'hFFFF, K_STROBE);
    xfer(16'h0102, 1'b1, 16'h7777, K_WD);
    check("pin_wd_reg2", regs_out[47:32], 16'h0000);
    xfer(16'h0100, 1'b0, 16'h0000, K_STROBE);

    xfer(16'h0102, 1'b1, 16'h4321, K_HOLD);
    reset_n = 1'b0;
    #1;
    check("arst_tready", bus.TargetReady, 1'b0);
    check("arst_oe", bus.rdata_oe, 1'b0);
    check("arst_regs", regs_out, 128'h0);
    check("arst_abort", abort_count, 8'h0);
    model_reset();
    bus.addressvalid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    xfer(16'h0105, 1'b1, 16'hCAFE, K_STROBE);
    check("pin_reg5", regs_out[95:80], 16'hCAFE);
    xfer(16'h0105, 1'b0, 16'h0000, K_STROBE);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
